// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: CSR instructions, ecall entry and mret return.
// Walks mepc/mcause/mstatus/mtvec one CSR access per cycle.
module trap_ctrl #(
    parameter int CSR_DIG = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_ecall,
    input  logic               is_mret,
    input  logic               is_csr,
    input  logic [1:0]         csr_op,
    input  logic [CSR_DIG-1:0] csr_addr,
    input  logic [31:0]        src,
    input  logic [31:0]        pc,
    output logic [CSR_DIG-1:0] csr_read_addr,
    input  logic [31:0]        csr_rdata,
    output logic               csr_write,
    output logic [CSR_DIG-1:0] csr_write_addr,
    output logic [31:0]        csr_data,
    output logic               rd_we,
    output logic [31:0]        rd_wdata,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSR,
        S_EPC,
        S_CAUSE,
        S_STAT,
        S_TVEC,
        S_MSTAT,
        S_MEPC
    } state_e;

    localparam logic [CSR_DIG-1:0] A_MSTATUS = CSR_DIG'(12'h300);
    localparam logic [CSR_DIG-1:0] A_MTVEC   = CSR_DIG'(12'h305);
    localparam logic [CSR_DIG-1:0] A_MEPC    = CSR_DIG'(12'h341);
    localparam logic [CSR_DIG-1:0] A_MCAUSE  = CSR_DIG'(12'h342);

    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

    state_e             state_q, state_d;
    logic [31:0]        pc_q;
    logic [31:0]        src_q;
    logic [CSR_DIG-1:0] addr_q;
    logic [1:0]         op_q;

    logic        accept;
    logic [31:0] csr_new;
    logic        csr_wen;
    logic [31:0] stat_trap;
    logic [31:0] stat_ret;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid & in_ready;

    // Next-state selection; ecall outranks mret, which outranks csr.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_ecall)     state_d = S_EPC;
                    else if (is_mret) state_d = S_MSTAT;
                    else if (is_csr)  state_d = S_CSR;
                    else              state_d = S_IDLE;
                end
            end
            S_CSR:   state_d = S_IDLE;
            S_EPC:   state_d = S_CAUSE;
            S_CAUSE: state_d = S_STAT;
            S_STAT:  state_d = S_TVEC;
            S_TVEC:  state_d = S_IDLE;
            S_MSTAT: state_d = S_MEPC;
            S_MEPC:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register and request capture on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            src_q   <= '0;
            addr_q  <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q   <= pc;
                src_q  <= src;
                addr_q <= csr_addr;
                op_q   <= csr_op;
            end
        end
    end

    // CSR read-modify-write value; op 00 behaves as RW.
    always_comb begin
        csr_new = src_q;
        csr_wen = 1'b1;
        unique case (op_q)
            2'b10: begin
                csr_new = csr_rdata | src_q;
                csr_wen = (src_q != 32'd0);
            end
            2'b11: begin
                csr_new = csr_rdata & ~src_q;
                csr_wen = (src_q != 32'd0);
            end
            default: begin
                csr_new = src_q;
                csr_wen = 1'b1;
            end
        endcase
    end

    // mstatus update for trap entry and for mret.
    always_comb begin
        stat_trap        = csr_rdata;
        stat_trap[7]     = csr_rdata[3];
        stat_trap[3]     = 1'b0;
        stat_trap[12:11] = 2'b11;
        stat_ret         = csr_rdata;
        stat_ret[3]      = csr_rdata[7];
        stat_ret[7]      = 1'b1;
        stat_ret[12:11]  = 2'b11;
    end

    // Per-state CSR port, writeback and redirect drive.
    always_comb begin
        csr_read_addr  = '0;
        csr_write      = 1'b0;
        csr_write_addr = '0;
        csr_data       = '0;
        rd_we          = 1'b0;
        rd_wdata       = '0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        done           = 1'b0;
        unique case (state_q)
            S_CSR: begin
                csr_read_addr = addr_q;
                rd_we         = 1'b1;
                rd_wdata      = csr_rdata;
                done          = 1'b1;
                if (csr_wen) begin
                    csr_write      = 1'b1;
                    csr_write_addr = addr_q;
                    csr_data       = csr_new;
                end
            end
            S_EPC: begin
                csr_write      = 1'b1;
                csr_write_addr = A_MEPC;
                csr_data       = pc_q;
            end
            S_CAUSE: begin
                csr_write      = 1'b1;
                csr_write_addr = A_MCAUSE;
                csr_data       = CAUSE_ECALL_M;
            end
            S_STAT: begin
                csr_read_addr  = A_MSTATUS;
                csr_write      = 1'b1;
                csr_write_addr = A_MSTATUS;
                csr_data       = stat_trap;
            end
            S_TVEC: begin
                csr_read_addr = A_MTVEC;
                redirect      = 1'b1;
                redirect_pc   = {csr_rdata[31:2], 2'b00};
                done          = 1'b1;
            end
            S_MSTAT: begin
                csr_read_addr  = A_MSTATUS;
                csr_write      = 1'b1;
                csr_write_addr = A_MSTATUS;
                csr_data       = stat_ret;
            end
            S_MEPC: begin
                csr_read_addr = A_MEPC;
                redirect      = 1'b1;
                redirect_pc   = csr_rdata;
                done          = 1'b1;
            end
            default: begin
                csr_read_addr = '0;
            end
        endcase
    end

endmodule
